// File: rtl/hack_pkg.sv
// Shared encodings for the Hack program-counter sequencer: FSM states and
// the instruction bit positions the jump logic decodes.
package hack_pkg;

   typedef enum logic [2:0] {
      ST_RST,
      ST_IDLE,
      ST_FETCH,
      ST_EXEC,
      ST_UPDATE,
      ST_HALT,
      ST_FAULT
   } state_e;

   localparam int INSTR_C_BIT = 15;
   localparam int JUMP_LSB = 0;
   localparam logic [2:0] JMP_ALWAYS = 3'b111;

endpackage

// File: rtl/pc_sequencer_jump_cond.sv
// Combinational Hack jump evaluation: j1 tests negative, j2 zero, j3 positive.
// A-instructions (C bit clear) never jump.
module jump_cond
   import hack_pkg::*;
(
   input  logic       c_bit,
   input  logic [2:0] jump_bits,
   input  logic       zr,
   input  logic       ng,
   output logic       take,
   output logic       uncond
);

   always_comb begin
      take   = c_bit & ((jump_bits[2] & ng) | (jump_bits[1] & zr) | (jump_bits[0] & ~zr & ~ng));
      uncond = c_bit & (jump_bits == JMP_ALWAYS);
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute controller for the Hack PC: sequences ROM fetch, waits for the
// datapath, then steps or loads the PC; detects self-jump halt and fetch timeout.
module pc_sequencer
   import hack_pkg::*;
#(
   parameter int WIDTH         = 16,
   parameter int RESET_CYCLES  = 2,
   parameter int FETCH_TIMEOUT = 15
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             run,
   output logic             fetch_req,
   input  logic             instr_valid,
   input  logic [WIDTH-1:0] instr,
   input  logic             exec_done,
   input  logic             zr,
   input  logic             ng,
   input  logic [WIDTH-1:0] a_reg,
   input  logic [WIDTH-1:0] pc_out,
   output logic [WIDTH-1:0] pc_in,
   output logic             pc_load,
   output logic             pc_inc,
   output logic             pc_reset,
   output logic [WIDTH-1:0] instr_q,
   output logic             halted,
   output logic             fault
);

   localparam logic [15:0] RST_LAST = 16'(RESET_CYCLES - 1);
   localparam logic [15:0] TO_LAST  = 16'(FETCH_TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [15:0]      rst_cnt_q, rst_cnt_d;
   logic [15:0]      to_cnt_q, to_cnt_d;
   logic [WIDTH-1:0] instr_d;
   logic             take_q, take_d;
   logic             take, uncond;

   jump_cond u_jump_cond (
      .c_bit     (instr_q[INSTR_C_BIT]),
      .jump_bits (instr_q[JUMP_LSB +: 3]),
      .zr        (zr),
      .ng        (ng),
      .take      (take),
      .uncond    (uncond)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_RST;
         rst_cnt_q <= '0;
         to_cnt_q  <= '0;
         instr_q   <= '0;
         take_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rst_cnt_q <= rst_cnt_d;
         to_cnt_q  <= to_cnt_d;
         instr_q   <= instr_d;
         take_q    <= take_d;
      end
   end

   // The jump decision is captured on the exec_done cycle so UPDATE does not
   // depend on the flags still being valid one cycle later.
   always_comb begin
      state_d   = state_q;
      rst_cnt_d = rst_cnt_q;
      to_cnt_d  = to_cnt_q;
      instr_d   = instr_q;
      take_d    = take_q;
      unique case (state_q)
         ST_RST: begin
            if (rst_cnt_q == RST_LAST) begin
               state_d   = ST_IDLE;
               rst_cnt_d = '0;
            end else begin
               rst_cnt_d = rst_cnt_q + 16'd1;
            end
         end
         ST_IDLE: begin
            to_cnt_d = '0;
            if (run) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (instr_valid) begin
               instr_d = instr;
               state_d = ST_EXEC;
            end else if ((FETCH_TIMEOUT != 0) && (to_cnt_q == TO_LAST)) begin
               state_d = ST_FAULT;
            end else begin
               to_cnt_d = to_cnt_q + 16'd1;
            end
         end
         ST_EXEC: begin
            if (exec_done) begin
               take_d  = take;
               state_d = (uncond && (a_reg == pc_out)) ? ST_HALT : ST_UPDATE;
            end
         end
         ST_UPDATE: state_d = ST_IDLE;
         ST_HALT:   state_d = ST_HALT;
         ST_FAULT:  state_d = ST_FAULT;
         default:   state_d = ST_RST;
      endcase
   end

   always_comb begin
      pc_in     = a_reg;
      pc_reset  = (state_q == ST_RST);
      fetch_req = (state_q == ST_FETCH);
      pc_load   = (state_q == ST_UPDATE) && take_q;
      pc_inc    = (state_q == ST_UPDATE) && !take_q;
      halted    = (state_q == ST_HALT);
      fault     = (state_q == ST_FAULT);
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; models the hPC register so PC movement
// can be checked against hand-computed addresses.
module tb_pc_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic        run;
   logic        fetchReq;
   logic        instrValid;
   logic [15:0] instr;
   logic        execDone;
   logic        zr;
   logic        ng;
   logic [15:0] aReg;
   logic [15:0] pcOut;
   logic [15:0] pcIn;
   logic        pcLoad;
   logic        pcInc;
   logic        pcReset;
   logic [15:0] instrQ;
   logic        halted;
   logic        fault;

   int checkCount = 0;
   int passCount = 0;
   int failCount = 0;
   int cycles;

   pc_sequencer dut (
      .clock       (clock),
      .reset       (reset),
      .run         (run),
      .fetch_req   (fetchReq),
      .instr_valid (instrValid),
      .instr       (instr),
      .exec_done   (execDone),
      .zr          (zr),
      .ng          (ng),
      .a_reg       (aReg),
      .pc_out      (pcOut),
      .pc_in       (pcIn),
      .pc_load     (pcLoad),
      .pc_inc      (pcInc),
      .pc_reset    (pcReset),
      .instr_q     (instrQ),
      .halted      (halted),
      .fault       (fault)
   );

   always #5 clock = ~clock;

   // Behavioural hPC: synchronous reset has priority over load, load over inc.
   always @(posedge clock) begin
      if (pcReset)     pcOut <= 16'h0000;
      else if (pcLoad) pcOut <= pcIn;
      else if (pcInc)  pcOut <= pcOut + 16'h0001;
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Drives one instruction from IDLE through FETCH and EXEC; returns in UPDATE/HALT.
   task automatic applyStimulus(input logic [15:0] word, input logic z, input logic n, input logic [15:0] a);
      run  = 1'b1;
      aReg = a;
      step();
      run        = 1'b0;
      instr      = word;
      instrValid = 1'b1;
      step();
      instrValid = 1'b0;
      execDone   = 1'b1;
      zr         = z;
      ng         = n;
      step();
      execDone = 1'b0;
      zr       = 1'b0;
      ng       = 1'b0;
   endtask

   task automatic releaseReset(output int n);
      reset = 1'b0;
      n = 0;
      while (pcReset && n < 10) begin
         n++;
         step();
      end
   endtask

   initial begin
      reset = 1'b1; run = 1'b0; instrValid = 1'b0; instr = 16'h0000;
      execDone = 1'b0; zr = 1'b0; ng = 1'b0; aReg = 16'h0000;

      repeat (3) step();
      checkOutput("rst_pc_reset", 16'(pcReset), 16'd1);
      checkOutput("rst_strobes", {12'd0, fetchReq, pcLoad, pcInc, halted}, 16'd0);
      checkOutput("rst_fault", 16'(fault), 16'd0);
      checkOutput("rst_instr_q", instrQ, 16'h0000);
      releaseReset(cycles);
      checkOutput("rst_len", 16'(cycles), 16'd2);
      checkOutput("idle_strobes", {12'd0, fetchReq, pcLoad, pcInc, pcReset}, 16'd0);
      checkOutput("idle_pc", pcOut, 16'h0000);

      run = 1'b1;
      step();
      checkOutput("fetch_req", 16'(fetchReq), 16'd1);
      run = 1'b0; instr = 16'h0005; instrValid = 1'b1;
      step();
      instrValid = 1'b0;
      checkOutput("exec_instr_q", instrQ, 16'h0005);
      checkOutput("exec_no_req", 16'(fetchReq), 16'd0);
      execDone = 1'b1;
      step();
      execDone = 1'b0;
      checkOutput("a_inc", {14'd0, pcLoad, pcInc}, 16'b01);
      step();
      checkOutput("a_pc", pcOut, 16'h0001);
      checkOutput("a_idle", {14'd0, pcLoad, pcInc}, 16'b00);

      applyStimulus(16'hE301, 1'b0, 1'b0, 16'h0010);
      checkOutput("jgt_load", {14'd0, pcLoad, pcInc}, 16'b10);
      checkOutput("jgt_pc_in", pcIn, 16'h0010);
      step();
      checkOutput("jgt_pc", pcOut, 16'h0010);

      applyStimulus(16'hE301, 1'b0, 1'b1, 16'h0020);
      checkOutput("jgt_neg_inc", {14'd0, pcLoad, pcInc}, 16'b01);
      step();
      checkOutput("jgt_neg_pc", pcOut, 16'h0011);

      applyStimulus(16'h0007, 1'b0, 1'b0, 16'h0030);
      checkOutput("ainst_nojump", {14'd0, pcLoad, pcInc}, 16'b01);
      step();
      checkOutput("ainst_pc", pcOut, 16'h0012);

      applyStimulus(16'hE306, 1'b1, 1'b0, 16'h0004);
      checkOutput("jle_zero_load", {14'd0, pcLoad, pcInc}, 16'b10);
      step();
      checkOutput("jle_pc", pcOut, 16'h0004);

      applyStimulus(16'hEA87, 1'b0, 1'b0, 16'h0004);
      checkOutput("halt_flag", 16'(halted), 16'd1);
      checkOutput("halt_no_strobe", {14'd0, pcLoad, pcInc}, 16'b00);
      run = 1'b1;
      repeat (3) step();
      run = 1'b0;
      checkOutput("halt_sticky", {14'd0, halted, fetchReq}, 16'b10);
      checkOutput("halt_pc", pcOut, 16'h0004);
      reset = 1'b1;
      #1;
      checkOutput("halt_cleared", 16'(halted), 16'd0);
      step();
      releaseReset(cycles);
      checkOutput("rst2_len", 16'(cycles), 16'd2);
      checkOutput("rst2_pc", pcOut, 16'h0000);

      run = 1'b1;
      step();
      run = 1'b0;
      cycles = 0;
      while (fetchReq && cycles < 40) begin
         cycles++;
         step();
      end
      checkOutput("timeout_len", 16'(cycles), 16'd15);
      checkOutput("fault_flag", {14'd0, fault, fetchReq}, 16'b10);
      reset = 1'b1;
      #1;
      checkOutput("fault_cleared", 16'(fault), 16'd0);
      step();
      releaseReset(cycles);
      checkOutput("rst3_len", 16'(cycles), 16'd2);

      applyStimulus(16'h0005, 1'b0, 1'b0, 16'h0000);
      step();
      checkOutput("pre_pc", pcOut, 16'h0001);
      run = 1'b1;
      step();
      run = 1'b0; instr = 16'hE301; instrValid = 1'b1;
      step();
      instrValid = 1'b0;
      checkOutput("exec_pre_reset", instrQ, 16'hE301);
      reset = 1'b1;
      #1;
      checkOutput("exec_reset_outs", {12'd0, pcReset, fetchReq, pcLoad, pcInc}, 16'b1000);
      checkOutput("exec_reset_iq", instrQ, 16'h0000);
      step();
      checkOutput("exec_reset_pc", pcOut, 16'h0000);
      releaseReset(cycles);
      checkOutput("rst4_len", 16'(cycles), 16'd2);
      checkOutput("rst4_idle", {12'd0, fetchReq, pcLoad, pcInc, halted}, 16'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
